// File: rtl/cmd_exec.sv
// Command executor: accepts tour commands, runs calibration or a turn followed by
// an N-square forward move with speed ramp, and pulses send_resp on completion.
module cmd_exec #(
    parameter logic [9:0] FRWRD_INC = 10'h010,
    parameter logic [9:0] MAX_SPD   = 10'h300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic [11:0] desired_heading,
    input  logic        heading_rdy,
    output logic        moving,
    output logic [9:0]  frwrd,
    input  logic        cntrIR,
    output logic        fanfare_go
);

    typedef enum logic [2:0] {IDLE, CAL, TURN, RAMP_UP, RAMP_DOWN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  sq_q, sq_d;
    logic [11:0] hdg_q, hdg_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ir_prev_q;
    logic        resp_q, resp_d;
    logic        strt_cal_q, strt_cal_d;
    logic        turn_first_q, turn_first_d;

    logic        ir_rise;
    logic [10:0] up_sum;
    logic [10:0] dn_step;
    logic [9:0]  ramp_up_val;
    logic [9:0]  ramp_dn_val;

    assign ir_rise = cntrIR & ~ir_prev_q;

    // Ramp arithmetic is done one bit wider so saturation never sees a wrapped value.
    assign up_sum      = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
    assign dn_step     = {FRWRD_INC, 1'b0};
    assign ramp_up_val = (up_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
    assign ramp_dn_val = ({1'b0, frwrd_q} > dn_step) ? (frwrd_q - dn_step[9:0]) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            sq_q         <= '0;
            hdg_q        <= '0;
            frwrd_q      <= '0;
            cnt_q        <= '0;
            ir_prev_q    <= 1'b0;
            resp_q       <= 1'b0;
            strt_cal_q   <= 1'b0;
            turn_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sq_q         <= sq_d;
            hdg_q        <= hdg_d;
            frwrd_q      <= frwrd_d;
            cnt_q        <= cnt_d;
            ir_prev_q    <= cntrIR;
            resp_q       <= resp_d;
            strt_cal_q   <= strt_cal_d;
            turn_first_q <= turn_first_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sq_d         = sq_q;
        hdg_d        = hdg_q;
        frwrd_d      = frwrd_q;
        cnt_d        = cnt_q;
        resp_d       = 1'b0;
        strt_cal_d   = 1'b0;
        turn_first_d = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = resp_q;
        fanfare_go   = 1'b0;

        case (state_q)
            IDLE: begin
                frwrd_d = '0;
                if (cmd_rdy && !rst) begin
                    clr_cmd_rdy = 1'b1;
                    op_d        = cmd[15:12];
                    sq_d        = cmd[3:0];
                    case (cmd[15:12])
                        4'h0: begin
                            state_d    = CAL;
                            strt_cal_d = 1'b1;
                        end
                        4'h2, 4'h3: begin
                            state_d      = TURN;
                            hdg_d        = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                            cnt_d        = '0;
                            turn_first_d = 1'b1;
                        end
                        default: resp_d = 1'b1;
                    endcase
                end
            end
            CAL: begin
                if (cal_done) begin
                    send_resp = 1'b1;
                    state_d   = IDLE;
                end
            end
            TURN: begin
                frwrd_d = '0;
                // heading_rdy may still reflect the previous heading on the entry cycle
                if (!turn_first_q && heading_rdy) begin
                    if (sq_q == 4'h0) begin
                        resp_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RAMP_UP;
                    end
                end
            end
            RAMP_UP: begin
                frwrd_d = ramp_up_val;
                if (ir_rise) cnt_d = cnt_q + 5'd1;
                if (cnt_q == {sq_q, 1'b0}) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (frwrd_q == '0) begin
                    send_resp  = 1'b1;
                    fanfare_go = (op_q == 4'h3);
                    state_d    = IDLE;
                end else begin
                    frwrd_d = ramp_dn_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign moving          = (state_q == TURN) || (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    assign strt_cal        = strt_cal_q;
    assign frwrd           = frwrd_q;
    assign desired_heading = hdg_q;

endmodule

// File: doc/cmd_exec.md
# cmd_exec

Command executor at the consuming end of the tour-command handshake. Accepts 16-bit commands from the command mux (`cmd`/`cmd_rdy`), acknowledges with `clr_cmd_rdy`, and executes them:

- calibration;
- heading change followed by an N-square forward move with a speed ramp.

It signals completion with a one-cycle `send_resp` pulse, which the command mux uses to advance to the next move and to form its response byte.

## Interface

Parameters:
- `FRWRD_INC`, default 10'h010: per-cycle forward-speed increment during ramp-up. Ramp-down uses 2×`FRWRD_INC`.
- `MAX_SPD`, default 10'h300: forward-speed saturation ceiling.

Ports:
- `clk`  in  1  system clock. One clock domain; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd`  in  16  command. Fields: [15:12] opcode, [11:4] heading, [3:0] squares.
- `cmd_rdy`  in  1  command valid. Held high by the source until it is cleared.
- `clr_cmd_rdy`  out  1  one-cycle acknowledge. `cmd` is latched in the same cycle.
- `send_resp`  out  1  one-cycle completion pulse.
- `strt_cal`  out  1  one-cycle calibration start pulse.
- `cal_done`  in  1  calibration complete.
- `desired_heading`  out  12  heading target.
- `heading_rdy`  in  1  heading error within tolerance.
- `moving`  out  1  high while turning or driving.
- `frwrd`  out  10  forward speed command.
- `cntrIR`  in  1  center line sensor. Already synchronous to `clk`.
- `fanfare_go`  out  1  one-cycle pulse at the end of a fanfare move.

## Operation

States: IDLE, CAL, TURN, RAMP_UP, RAMP_DOWN.

IDLE
- When `cmd_rdy`=1, assert `clr_cmd_rdy` combinationally that cycle and latch `cmd` at the clock edge.
- Next state depends on the latched opcode:
  - 4'h0 (calibrate) → CAL; `strt_cal` pulses in the first CAL cycle.
  - 4'h2 (move) or 4'h3 (move with fanfare) → TURN.
  - Any other opcode: consumed; `send_resp` pulses the next cycle; stay in IDLE.

CAL
- On `cal_done`=1: pulse `send_resp`, return to IDLE.

TURN
- On entry, `desired_heading` is loaded:
  - heading field = 8'h00 → 12'h000;
  - otherwise → {heading, 4'hF}.
- `moving`=1 and `frwrd`=0 throughout TURN.
- `heading_rdy` is sampled starting the cycle after entry. When it is 1:
  - squares = 0 → pulse `send_resp`, go to IDLE;
  - otherwise → RAMP_UP.

RAMP_UP
- `frwrd` increases by `FRWRD_INC` each cycle, saturating at `MAX_SPD`. No wrap.
- A 5-bit counter, cleared on entry to TURN, counts rising edges of `cntrIR` using a registered previous-value detect.
- When the count equals 2×squares (each square is two line crossings) → RAMP_DOWN.

RAMP_DOWN
- `frwrd` decreases by 2×`FRWRD_INC` each cycle, saturating at 0. No underflow.
- `cntrIR` edges are ignored.
- In the cycle `frwrd`=0:
  - pulse `send_resp`;
  - pulse `fanfare_go` in the same cycle if opcode = 4'h3;
  - `moving` goes to 0 on the next edge;
  - go to IDLE.

Common rules
- `moving` is 1 in TURN, RAMP_UP and RAMP_DOWN; 0 otherwise.
- `desired_heading` holds its value in every state until the next move command loads it.
- `cmd_rdy` while not in IDLE is ignored: no `clr_cmd_rdy` is issued until the FSM is back in IDLE.

## Timing

- Reset values, applied asynchronously, also when `rst` asserts mid-operation:
  - state = IDLE, counter = 0;
  - `clr_cmd_rdy`, `send_resp`, `strt_cal`, `fanfare_go`, `moving` = 0;
  - `frwrd` = 10'h000, `desired_heading` = 12'h000.
- Acknowledge latency: `clr_cmd_rdy` is asserted in the first IDLE cycle in which `cmd_rdy`=1.
- Latency for an unsupported opcode: `send_resp` is 1 cycle after `clr_cmd_rdy`.
- A `cntrIR` rising edge is counted on the cycle after `cntrIR` goes 1.
- Reaching the edge target in the same cycle as `frwrd` saturates: go to RAMP_DOWN; the saturated value is the ramp-down start.
- 2×squares ≤ 30 fits the 5-bit counter; squares = 15 is a legal boundary.
- Each of `send_resp`, `strt_cal`, `fanfare_go` and `clr_cmd_rdy` is exactly one cycle wide, never back-to-back for a single command.

## Test plan

- Calibrate: `cmd`=16'h0000 with `cmd_rdy`. Required: `clr_cmd_rdy` 1 cycle, `strt_cal` 1 cycle; `cal_done` 20 cycles later → `send_resp` 1 cycle; `moving` stays 0.
- Move east 1: `cmd`=16'h2BF1. Required:
  - `desired_heading`=12'hBFF, `moving`=1, `frwrd`=0 until `heading_rdy`;
  - `frwrd` ramps by 10'h010 and holds at 10'h300;
  - after 2 `cntrIR` edges, ramps down by 10'h020 to 0;
  - `send_resp` 1 cycle, no `fanfare_go`.
- Fanfare north 2: `cmd`=16'h3002. Required: `desired_heading`=12'h000; ramp-down begins only after the 4th edge; `send_resp` and `fanfare_go` in the same cycle. Edges during TURN/RAMP_DOWN do not count.
- Zero squares, then bad opcode:
  - `cmd`=16'h2BF0 → `send_resp` the cycle after `heading_rdy`, `frwrd` never nonzero.
  - `cmd`=16'h7000 → `send_resp` 1 cycle after `clr_cmd_rdy`.
- Busy and reset: assert `cmd_rdy` during RAMP_UP → no `clr_cmd_rdy` until IDLE. Assert `rst` mid-RAMP_UP → all outputs at their reset values immediately (asynchronously); the next command executes normally.
